freq_period_meter: RTL and testbench

- Measures the period and high time of a divided clock (for example the frequency divider output, or a DCO output) in reference `clk` cycles.
- It is the measuring end of the divider path: the divider turns a count into a waveform; this block recovers the count from the waveform.
- It sits in the ADPLL feedback path and supplies the period error measurement to the loop filter.
- Input is treated as asynchronous: synchroniser, edge detector, counter FSM.

---
 rtl/freq_period_meter.sv | 147 ++++++++++++++
 tb/tb_freq_period_meter.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/freq_period_meter.sv
// Measures rise-to-rise period and rise-to-fall high time of an asynchronous
// waveform in reference clk cycles; feeds the ADPLL period-error path.
module freq_period_meter #(
  parameter int unsigned CNT_W       = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             sig_in,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             meas_valid,
  output logic             overflow,
  output logic             stable
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARMED,
    ST_MEASURE
  } state_t;

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_s_d;
  logic                   r_rise;
  logic                   r_fall;
  logic                   w_s;

  state_t                 r_state,   w_state;
  logic [CNT_W-1:0]       r_cnt,     w_cnt;
  logic [CNT_W-1:0]       r_period,  w_period;
  logic [CNT_W-1:0]       r_high,    w_high;
  logic [CNT_W-1:0]       r_prev,    w_prev;
  logic                   r_valid,   w_valid;
  logic                   r_ovf,     w_ovf;
  logic                   r_stable,  w_stable;
  logic                   r_hi_seen, w_hi_seen;

  assign w_s = r_sync[SYNC_STAGES-1];

  // Synchroniser and registered edge detect; the extra edge stage gives the
  // SYNC_STAGES+1 latency from sampled rise to meas_valid.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync <= '0;
      r_s_d  <= 1'b0;
      r_rise <= 1'b0;
      r_fall <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], sig_in};
      r_s_d  <= w_s;
      r_rise <= w_s & ~r_s_d;
      r_fall <= ~w_s & r_s_d;
    end
  end

  // State and measurement registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_period  <= '0;
      r_high    <= '0;
      r_prev    <= '0;
      r_valid   <= 1'b0;
      r_ovf     <= 1'b0;
      r_stable  <= 1'b0;
      r_hi_seen <= 1'b0;
    end else begin
      r_state   <= w_state;
      r_cnt     <= w_cnt;
      r_period  <= w_period;
      r_high    <= w_high;
      r_prev    <= w_prev;
      r_valid   <= w_valid;
      r_ovf     <= w_ovf;
      r_stable  <= w_stable;
      r_hi_seen <= w_hi_seen;
    end
  end

  // Next-state and measurement update; a rise takes priority over saturation.
  always_comb begin
    w_state   = r_state;
    w_cnt     = r_cnt;
    w_period  = r_period;
    w_high    = r_high;
    w_prev    = r_prev;
    w_valid   = 1'b0;
    w_ovf     = r_ovf;
    w_stable  = r_stable;
    w_hi_seen = r_hi_seen;

    if (!en) begin
      w_state  = ST_IDLE;
      w_cnt    = '0;
      w_stable = 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          w_cnt   = '0;
          w_state = ST_ARMED;
        end
        ST_ARMED: begin
          if (r_rise) begin
            w_cnt     = CNT_W'(1);
            w_hi_seen = 1'b0;
            w_state   = ST_MEASURE;
          end
        end
        ST_MEASURE: begin
          if (r_rise) begin
            w_period  = r_cnt;
            w_valid   = 1'b1;
            w_cnt     = CNT_W'(1);
            w_stable  = (r_cnt == r_prev);
            w_prev    = r_cnt;
            w_ovf     = 1'b0;
            w_hi_seen = 1'b0;
          end else if (r_cnt == CNT_MAX) begin
            w_ovf    = 1'b1;
            w_stable = 1'b0;
            w_cnt    = '0;
            w_state  = ST_ARMED;
          end else begin
            w_cnt = r_cnt + CNT_W'(1);
            if (r_fall && !r_hi_seen) begin
              w_high    = r_cnt;
              w_hi_seen = 1'b1;
            end
          end
        end
        default: w_state = ST_IDLE;
      endcase
    end
  end

  assign period     = r_period;
  assign high_time  = r_high;
  assign meas_valid = r_valid;
  assign overflow   = r_ovf;
  assign stable     = r_stable;

endmodule

// File: tb/tb_freq_period_meter.sv
// Bench for freq_period_meter: directed and random waveforms checked every
// cycle against a timestamp-based reference model.
module tb_freq_period_meter;

  localparam int unsigned CNT_W = 8;
  localparam int unsigned SS    = 2;
  localparam int          LAT   = SS + 1;
  localparam int          CMAX  = (1 << CNT_W) - 1;

  logic             clk;
  logic             reset;
  logic             en;
  logic             sig_in;
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] high_time;
  logic             meas_valid;
  logic             overflow;
  logic             stable;

  freq_period_meter #(.CNT_W(CNT_W), .SYNC_STAGES(SS)) dut (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .sig_in     (sig_in),
    .period     (period),
    .high_time  (high_time),
    .meas_valid (meas_valid),
    .overflow   (overflow),
    .stable     (stable)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int n_valid  = 0;
  int edge_n   = 0;

  // Reference model state: phase 0 = disabled, 1 = waiting for first rise,
  // 2 = timing from the rise at edge t_start.
  bit samp [0:65535];
  int phase   = 0;
  int t_start = 0;
  bit hi      = 1'b0;
  int m_period = 0, m_high = 0, m_prev = 0;
  bit m_valid = 1'b0, m_ovf = 1'b0, m_stable = 1'b0;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, got, exp, edge_n);
    end
  endtask

  function automatic bit samp_at(input int k);
    if (k < 0) return 1'b0;
    return samp[k[15:0]];
  endfunction

  task automatic model_edge(input bit e);
    int j;
    bit r, f;
    int el;
    j = edge_n;
    r = samp_at(j - LAT) && !samp_at(j - LAT - 1);
    f = !samp_at(j - LAT) && samp_at(j - LAT - 1);
    m_valid = 1'b0;
    if (!e) begin
      phase    = 0;
      m_stable = 1'b0;
    end else if (phase == 0) begin
      phase = 1;
    end else if (phase == 1) begin
      if (r) begin
        t_start = j;
        hi      = 1'b0;
        phase   = 2;
      end
    end else begin
      el = j - t_start;
      if (r) begin
        m_period = el;
        m_valid  = 1'b1;
        m_stable = (el == m_prev);
        m_prev   = el;
        m_ovf    = 1'b0;
        t_start  = j;
        hi       = 1'b0;
      end else if (el >= CMAX) begin
        m_ovf    = 1'b1;
        m_stable = 1'b0;
        phase    = 1;
      end else if (f && !hi) begin
        m_high = el;
        hi     = 1'b1;
      end
    end
  endtask

  task automatic check_outputs();
    check_eq("period",     int'(period),     m_period);
    check_eq("high_time",  int'(high_time),  m_high);
    check_eq("meas_valid", int'(meas_valid), int'(m_valid));
    check_eq("overflow",   int'(overflow),   int'(m_ovf));
    check_eq("stable",     int'(stable),     int'(m_stable));
  endtask

  // One clk cycle: drive, model the edge, then sample outputs 2 time units later.
  task automatic tick(input bit s, input bit e);
    int j;
    sig_in = s;
    en     = e;
    @(posedge clk);
    j = edge_n;
    samp[j[15:0]] = s;
    model_edge(e);
    edge_n++;
    #2;
    check_outputs();
    if (meas_valid) begin
      n_valid++;
      check_eq("valid_lat", int'(samp_at(j - LAT) & ~samp_at(j - LAT - 1)), 1);
    end
  endtask

  task automatic do_reset();
    #1 reset = 1'b1;
    #1;
    check_eq("rst_period",     int'(period),     0);
    check_eq("rst_high_time",  int'(high_time),  0);
    check_eq("rst_meas_valid", int'(meas_valid), 0);
    check_eq("rst_overflow",   int'(overflow),   0);
    check_eq("rst_stable",     int'(stable),     0);
    #1 reset = 1'b0;
    phase = 0; t_start = 0; hi = 1'b0;
    m_period = 0; m_high = 0; m_prev = 0;
    m_valid = 1'b0; m_ovf = 1'b0; m_stable = 1'b0;
    for (int k = 1; k <= LAT + 1; k++) begin
      if (edge_n - k >= 0) samp[16'(edge_n - k)] = 1'b0;
    end
  endtask

  // n periods of hi/lo cycles; en low for dlen cycles starting at cycle d0.
  task automatic wave(input int h, input int l, input int n, input int d0, input int dlen);
    int per;
    per = h + l;
    for (int c = 0; c < n * per; c++) begin
      tick(bit'((c % per) < h), bit'(!(c >= d0 && c < d0 + dlen)));
    end
  endtask

  initial begin
    int h, l, n, d0, dlen;
    reset  = 1'b1;
    en     = 1'b0;
    sig_in = 1'b0;
    #12;
    check_eq("init_period",     int'(period),     0);
    check_eq("init_high_time",  int'(high_time),  0);
    check_eq("init_meas_valid", int'(meas_valid), 0);
    check_eq("init_overflow",   int'(overflow),   0);
    check_eq("init_stable",     int'(stable),     0);
    reset = 1'b0;

    tick(1'b0, 1'b1);
    tick(1'b0, 1'b1);
    wave(4, 4, 6, 0, 0);
    wave(4, 4, 1, 0, 2);
    tick(1'b1, 1'b1);
    tick(1'b1, 1'b1);
    do_reset();
    tick(1'b1, 1'b1);
    tick(1'b1, 1'b1);
    wave(4, 4, 5, 0, 0);
    wave(3, 3, 5, 0, 0);
    wave(3, 300, 1, 0, 0);
    wave(3, 3, 4, 0, 0);
    wave(100, 155, 3, 0, 0);
    wave(1, 1, 8, 0, 0);
    wave(4, 4, 8, 13, 10);

    for (int seg = 0; seg < 40; seg++) begin
      h = int'($urandom_range(1, 12));
      l = ($urandom_range(0, 9) == 0) ? int'($urandom_range(240, 270))
                                      : int'($urandom_range(1, 12));
      n = int'($urandom_range(1, 4));
      d0 = 0; dlen = 0;
      if ($urandom_range(0, 6) == 0) begin
        d0   = int'($urandom_range(0, n * (h + l) - 1));
        dlen = int'($urandom_range(1, 12));
      end
      wave(h, l, n, d0, dlen);
      if ($urandom_range(0, 19) == 0) do_reset();
    end

    check_eq("valid_seen", int'(n_valid > 20), 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
